// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO and valid/ready write port
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   head;

    // Ready comes only from registered count, so a full FIFO rejects even when a pop coincides
    assign tx_ready   = (count_q != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign bit_end    = (cnt_q == CNT_LAST);
    assign head       = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Frame sequencing; tx_d is the line level for the clock after this edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            bit_d   = '0;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading a word starts the start bit on the very next clock
        if (pop) begin
            state_d = S_START;
            tx_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            shreg_d = head;
            par_d   = (PARITY == 2) ? ~^head : ^head;
        end
    end

    // FIFO pointers, occupancy and storage, plus the registered busy flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        busy_d   = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // Control state; reset aborts any frame and flushes the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    logic [2:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int model_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld[0]), .tx_data(d0),
        .tx_ready(rdy[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt0));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld[1]), .tx_data(d1),
        .tx_ready(rdy[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt1));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld[2]), .tx_data(d2),
        .tx_ready(rdy[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt2));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int parity_bit(input int word, input int nbits, input int par);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += (word >> i) & 1;
        return (par == 1) ? (ones % 2) : (1 - (ones % 2));
    endfunction

    task automatic set_data(input int inst, input int word);
        case (inst)
            0:       d0 = word[7:0];
            1:       d1 = word[6:0];
            default: d2 = word[7:0];
        endcase
    endtask

    // Expected line levels come from the frame layout: start, data LSB first, parity, stops
    task automatic check_frame(input int inst, input int word, input int nbits,
                               input int par, input int stops, output int gap);
        int bits[16];
        int nb;
        bits[0] = 0;
        nb = 1;
        for (int i = 0; i < nbits; i++) begin
            bits[nb] = (word >> i) & 1;
            nb++;
        end
        if (par != 0) begin
            bits[nb] = parity_bit(word, nbits, par);
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            bits[nb] = 1;
            nb++;
        end
        gap = 0;
        while (tx_v[inst] !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        check_eq($sformatf("i%0d_start_seen", inst), {31'd0, tx_v[inst]}, 32'd0);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check_eq($sformatf("i%0d_w%0h_bit%0d_clk%0d", inst, word, b, c),
                         {31'd0, tx_v[inst]}, bits[b]);
                if (b == nb - 1 && c == CPB - 1)
                    check_eq($sformatf("i%0d_busy_last", inst), {31'd0, busy_v[inst]}, 32'd1);
                @(negedge clk);
            end
        end
    endtask

    task automatic push_one(input int inst, input int word);
        int k = 0;
        set_data(inst, word);
        vld[inst] = 1'b1;
        while (!rdy[inst] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq($sformatf("i%0d_push_ready", inst), {31'd0, rdy[inst]}, 32'd1);
        @(negedge clk);
        vld[inst] = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int k = 0;
        while (busy_v[inst] !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq($sformatf("i%0d_idle", inst), {31'd0, busy_v[inst]}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int w[6];
        int acc_cyc[6];
        int lows;

        reset_n = 1'b0;
        vld = '0;
        d0 = '0;
        d1 = '0;
        d2 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx_v[0]}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check_eq("rst_count", {29'd0, cnt0}, 32'd0);
        check_eq("rst_ready", {31'd0, rdy[0]}, 32'd1);
        check_eq("rst_tx_7o2", {31'd0, tx_v[1]}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Single 8N1 word
        set_data(0, 8'hA5);
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        check_frame(0, 8'hA5, 8, 0, 1, gap);
        check_eq("t1_gap", gap, 32'd1);
        check_eq("t1_busy_after", {31'd0, busy_v[0]}, 32'd0);
        check_eq("t1_tx_after", {31'd0, tx_v[0]}, 32'd1);

        // Six words offered continuously into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom_range(0, 255);
            acc_cyc[i] = -1;
        end
        fork
            begin
                int idx = 0;
                int cyc = 0;
                logic acc;
                vld[0] = 1'b1;
                set_data(0, w[0]);
                while (idx < 6 && cyc < 1000) begin
                    if (cyc == 5) begin
                        check_eq("t2_full_count", {29'd0, cnt0}, 32'd4);
                        check_eq("t2_full_ready", {31'd0, rdy[0]}, 32'd0);
                    end
                    if (cyc == 102) begin
                        check_eq("t6_pop_count", {29'd0, cnt0}, 32'd3);
                        check_eq("t6_pop_ready", {31'd0, rdy[0]}, 32'd1);
                    end
                    acc = rdy[0];
                    @(negedge clk);
                    if (acc) begin
                        acc_cyc[idx] = cyc;
                        idx++;
                        if (idx < 6) set_data(0, w[idx]);
                        else vld[0] = 1'b0;
                    end
                    cyc++;
                end
                vld[0] = 1'b0;
                check_eq("t6_refill_count", {29'd0, cnt0}, 32'd4);
                for (int i = 0; i < 5; i++)
                    check_eq($sformatf("t2_accept%0d", i), acc_cyc[i], i);
                check_eq("t2_accept5", acc_cyc[5], 32'd102);
            end
            begin
                int g;
                for (int i = 0; i < 6; i++) begin
                    check_frame(0, w[i], 8, 0, 1, g);
                    check_eq($sformatf("t2_gap%0d", i), g, (i == 0) ? 32'd2 : 32'd0);
                end
            end
        join
        wait_idle(0);
        check_eq("t2_count_end", {29'd0, cnt0}, 32'd0);

        // 7 data bits, odd parity, two stops; then 8 bits even parity
        push_one(1, 7'h41);
        check_frame(1, 7'h41, 7, 2, 2, gap);
        push_one(2, 8'h03);
        check_frame(2, 8'h03, 8, 1, 1, gap);
        push_one(2, 8'h07);
        check_frame(2, 8'h07, 8, 1, 1, gap);
        for (int i = 0; i < 4; i++) begin
            int r1 = $urandom_range(0, 127);
            int r2 = $urandom_range(0, 255);
            push_one(1, r1);
            check_frame(1, r1, 7, 2, 2, gap);
            push_one(2, r2);
            check_frame(2, r2, 8, 1, 1, gap);
        end
        wait_idle(1);
        wait_idle(2);

        // Reset in the middle of the data bits with two words queued
        vld[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_data(0, $urandom_range(0, 255));
            @(negedge clk);
        end
        vld[0] = 1'b0;
        gap = 0;
        while (tx_v[0] !== 1'b0 && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        repeat (25) @(negedge clk);
        check_eq("t5_pre_count", {29'd0, cnt0}, 32'd2);
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", {31'd0, tx_v[0]}, 32'd1);
        check_eq("t5_rst_count", {29'd0, cnt0}, 32'd0);
        check_eq("t5_rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check_eq("t5_rst_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1) lows++;
        end
        check_eq("t5_no_frame", lows, 32'd0);

        // Random bursts and pauses against a word queue
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int pause = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 250)
                                                            : $urandom_range(0, 3);
                    int word = $urandom_range(0, 255);
                    int k = 0;
                    repeat (pause) @(negedge clk);
                    set_data(0, word);
                    vld[0] = 1'b1;
                    while (!rdy[0] && k < 2000) begin
                        @(negedge clk);
                        k++;
                    end
                    check_eq("rand_push_ready", {31'd0, rdy[0]}, 32'd1);
                    model_q.push_back(word);
                    @(negedge clk);
                    vld[0] = 1'b0;
                end
            end
            begin
                int g;
                for (int i = 0; i < 20; i++) begin
                    int k = 0;
                    while (model_q.size() == 0 && k < 3000) begin
                        @(negedge clk);
                        k++;
                    end
                    check_eq("rand_queue_ready", (model_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                    if (model_q.size() != 0) check_frame(0, model_q.pop_front(), 8, 0, 1, g);
                end
            end
        join
        wait_idle(0);
        check_eq("rand_count_end", {29'd0, cnt0}, 32'd0);
        check_eq("rand_tx_end", {31'd0, tx_v[0]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
